conv_output_collector: RTL and testbench

CONV_OUTPUT_COLLECTOR -- requirements
Module: conv_output_collector

---
 rtl/conv_output_collector.sv | 121 ++++++++++++
 tb/tb_conv_output_collector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_output_collector.sv
// Collects convolver results into a small FIFO, tagging each with its output-map row/col.
// Optional macro CONV_COLLECTOR_RELU_EN clamps negative results to zero before storage.
module conv_output_collector #(
   parameter int DATA_WIDTH  = 16,
   parameter int IMAGE_SIZE  = 28,
   parameter int KERNEL_SIZE = 5,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [4:0]            out_row,
   output logic [4:0]            out_col,
   output logic                  frame_done,
   output logic                  overflow,
   output logic                  busy
);

   localparam int OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
   localparam int PW       = $clog2(FIFO_DEPTH);
   localparam logic [4:0]  LAST_IDX = 5'(OUT_SIZE - 1);
   localparam logic [PW:0] DEPTH_C  = (PW+1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [4:0]            row;
      logic [4:0]            col;
      logic                  last;
   } entry_t;

   entry_t mem [FIFO_DEPTH];

   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PW:0]   count_reg, count_next;
   logic [4:0]    row_reg, row_next;
   logic [4:0]    col_reg, col_next;
   logic          overflow_reg, frame_done_reg;
   logic          empty, full, push, pop, last_tag;
   logic [DATA_WIDTH-1:0] stored_data;
   entry_t        head, push_entry;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == DEPTH_C);
   assign pop   = !empty && out_ready;
   assign push  = in_valid && (!full || pop);

`ifdef CONV_COLLECTOR_RELU_EN
   assign stored_data = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
   assign stored_data = in_data;
`endif

   assign last_tag   = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);
   assign push_entry = {stored_data, row_reg, col_reg, last_tag};

   // Geometry follows in_valid alone, so dropped samples still consume a position.
   always_comb begin
      row_next = row_reg;
      col_next = col_reg;
      if (in_valid) begin
         if (col_reg == LAST_IDX) begin
            col_next = '0;
            row_next = (row_reg == LAST_IDX) ? 5'd0 : row_reg + 5'd1;
         end else begin
            col_next = col_reg + 5'd1;
         end
      end
   end

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         row_reg        <= '0;
         col_reg        <= '0;
         overflow_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         row_reg        <= row_next;
         col_reg        <= col_next;
         count_reg      <= count_next;
         frame_done_reg <= pop && head.last;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         if (in_valid && full && !pop)
            overflow_reg <= 1'b1;
      end
   end

   // Storage carries no reset; the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= push_entry;
   end

   assign head       = mem[rd_ptr_reg];
   assign out_valid  = !empty;
   assign out_data   = empty ? '0 : head.data;
   assign out_row    = empty ? '0 : head.row;
   assign out_col    = empty ? '0 : head.col;
   assign frame_done = frame_done_reg;
   assign overflow   = overflow_reg;
   assign busy       = (row_reg != '0) || (col_reg != '0) || !empty;

endmodule

// File: tb/tb_conv_output_collector.sv
// Self-checking bench for conv_output_collector: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_conv_output_collector;

   localparam int OUT   = 24;
   localparam int FRAME = OUT * OUT;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [4:0]  out_row;
   logic [4:0]  out_col;
   logic        frame_done;
   logic        overflow;
   logic        busy;

   conv_output_collector dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_col    (out_col),
      .frame_done (frame_done),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      int          row;
      int          col;
      bit          last;
   } ent_t;

   ent_t q[$];
   int   idx;
   bit   fd_m;
   bit   ovf_m;
   int   fd_seen;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_data(input logic [15:0] d);
`ifdef CONV_COLLECTOR_RELU_EN
      return d[15] ? 16'd0 : d;
`else
      return d;
`endif
   endfunction

   // One clock cycle: drive inputs, compare registered outputs, advance the model.
   task automatic step(input logic iv, input logic [15:0] d, input logic rdy);
      bit   full_m, pop_m, push_m;
      ent_t e;
      in_valid  = iv;
      in_data   = d;
      out_ready = rdy;
      #1;
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check("out_data", 32'(out_data), 32'(q[0].d));
         check("out_row", 32'(out_row), 32'(q[0].row));
         check("out_col", 32'(out_col), 32'(q[0].col));
      end
      check("frame_done", 32'(frame_done), 32'(fd_m));
      check("overflow", 32'(overflow), 32'(ovf_m));
      check("busy", 32'(busy), 32'((idx != 0) || (q.size() != 0)));
      if (frame_done) fd_seen++;
      full_m = (q.size() == DEPTH);
      pop_m  = (q.size() != 0) && rdy;
      push_m = iv && (!full_m || pop_m);
      fd_m   = pop_m && q[0].last;
      if (iv && full_m && !pop_m) ovf_m = 1'b1;
      if (pop_m) e = q.pop_front();
      if (push_m) begin
         e.d    = model_data(d);
         e.row  = idx / OUT;
         e.col  = idx % OUT;
         e.last = (idx == FRAME - 1);
         q.push_back(e);
      end
      if (iv) idx = (idx + 1) % FRAME;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #2;
      rstn = 1'b0;
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_row", 32'(out_row), 32'd0);
      check("rst_out_col", 32'(out_col), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      q.delete();
      idx   = 0;
      fd_m  = 1'b0;
      ovf_m = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn      = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // One row of data 1..24 with the consumer always ready.
      for (int i = 1; i <= OUT; i++) step(1'b1, 16'(i), 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      $display("row test done checks=%0d", checks);

      // Full frame with 4-cycle row bubbles.
      do_reset();
      fd_seen = 0;
      for (int r = 0; r < OUT; r++) begin
         for (int c = 0; c < OUT; c++) step(1'b1, 16'($urandom), 1'b1);
         for (int g = 0; g < 4; g++) step(1'b0, '0, 1'b1);
      end
      check("frame_done_pulses", 32'(fd_seen), 32'd1);
      check("busy_after_frame", 32'(busy), 32'd0);
      $display("frame test done checks=%0d", checks);

      // Backpressure: nine pushes into eight entries, then drain.
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b1, 16'(i + 40), 1'b0);
      step(1'b0, '0, 1'b0);
      check("overflow_after_9", 32'(overflow), 32'd1);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
      step(1'b1, 16'd77, 1'b1);
      check("col_after_drop", 32'(out_col), 32'd9);
      step(1'b0, '0, 1'b1);
      $display("overflow test done checks=%0d", checks);

      // Full FIFO with simultaneous push and pop must not overflow.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 16'(i + 200), 1'b0);
      step(1'b1, 16'd300, 1'b1);
      step(1'b0, '0, 1'b0);
      check("overflow_full_pushpop", 32'(overflow), 32'd0);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
      $display("full push-pop test done checks=%0d", checks);

      // Reset in the middle of a frame.
      do_reset();
      for (int i = 0; i < 100; i++) step(1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
      do_reset();
      step(1'b1, 16'd7, 1'b1);
      check("post_reset_row", 32'(out_row), 32'd0);
      check("post_reset_col", 32'(out_col), 32'd0);
      step(1'b0, '0, 1'b1);

      // Negative sample.
      step(1'b1, 16'hFFFB, 1'b1);
      step(1'b0, '0, 1'b1);
      $display("reset/negative test done checks=%0d", checks);

      // Random traffic.
      do_reset();
      for (int i = 0; i < 1500; i++)
         step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0));
      for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
      $display("random test done checks=%0d", checks);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
